hilo_muldiv_unit: RTL and testbench
===================================

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width; HI and LO are each WIDTH bits.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start_i  input  1  request a mul/div operation; accepted only when busy_o=0.
REQ-005 op_i  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with an accepted start_i.
REQ-006 a_i, b_i  input  WIDTH  operands (rs, rt); sampled with an accepted start_i.
REQ-007 flush_i  input  1  abort the in-flight operation.
REQ-008 mthi_i, mtlo_i  input  1 each  write wdata_i into HI or LO.
REQ-009 wdata_i  input  WIDTH  MTHI/MTLO data.
REQ-010 busy_o  output  1  operation in progress; the pipeline stalls MFHI/MFLO/MTHI/MTLO/mul/div while high.
REQ-011 done_o  output  1  one-cycle pulse; HI/LO hold the new result in that same cycle.
REQ-012 div_zero_o  output  1  pulses with done_o when a DIV/DIVU had b_i=0.
REQ-013 hi_o, lo_o  output  WIDTH  architectural HI/LO registers, read by MFHI/MFLO.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC, FINISH; busy_o=1 in CALC and FINISH, else 0.
REQ-015 IDLE with start_i=1 SHALL latch op_i, |a_i|, |b_i| (magnitudes for MULT/DIV; raw values for unsigned ops) and result signs, clear the iteration counter, then go to CALC.
REQ-016 CALC SHALL perform one radix-2 step per cycle (shift-add for multiply, restoring subtract for divide) for exactly WIDTH cycles, then go to FINISH.
REQ-017 FINISH SHALL apply sign correction, write HI/LO, assert done_o in the following cycle, and return to IDLE.
REQ-018 Latency: done_o SHALL be high exactly WIDTH+2 cycles after the cycle in which start_i was accepted; back-to-back start is allowed in the done_o cycle.
REQ-019 Multiply: {HI,LO} SHALL equal the full 2*WIDTH-bit product, signed for MULT, unsigned for MULTU.
REQ-020 Divide: LO = quotient and HI = remainder; for DIV the quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-021 DIV of the most-negative value by -1 SHALL give LO = most-negative value, HI = 0, with no flag raised.
REQ-022 Divide by zero (both DIV and DIVU) SHALL complete with normal latency, giving HI = a_i, LO = all ones, and div_zero_o=1 with done_o.
REQ-023 start_i while busy_o=1 SHALL be ignored.
REQ-024 mthi_i/mtlo_i SHALL write HI/LO at the next edge only when busy_o=0 and start_i=0; they are ignored otherwise, so start_i wins a same-cycle conflict.
REQ-025 mthi_i and mtlo_i asserted together SHALL write wdata_i to both registers.
REQ-026 flush_i in CALC or FINISH SHALL return the FSM to IDLE at the next edge, leave HI/LO unchanged, and produce no done_o pulse; flush_i in IDLE has no effect, and flush_i has priority over a same-cycle start_i.
REQ-027 HI/LO SHALL change only on the FINISH write, an MTHI/MTLO write, or reset.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for a clock edge, force state IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, div_zero_o=0, and clear all datapath registers.
REQ-029 Reset mid-operation SHALL discard the operation; after rst is released, no done_o pulse occurs until a new start_i is accepted.

Verification (WIDTH=32)
REQ-030 MULT a=0xFFFFFFFD (-3), b=5 -> done_o after 34 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-031 MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 DIVU a=7, b=0 -> div_zero_o=1 with done_o, HI=0x00000007, LO=0xFFFFFFFF.
REQ-034 MTLO 0x1234 then MULTU 3*4 with flush_i at cycle 10 -> no done_o, LO stays 0x1234, busy_o low one cycle later; MTHI during busy is ignored.
REQ-035 rst asserted mid-CALC, asynchronous to clk -> all outputs 0 immediately; no later done_o until a new start.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Purpose : HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO) with iterative radix-2 datapath.
// Latency : done_o pulses WIDTH+2 cycles after start_i is accepted; HI/LO hold the result in that cycle.
// Backpres: busy_o high while an operation is in flight; start_i and MTHI/MTLO are ignored while busy.
module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   input  logic             mthi_i,
   input  logic             mtlo_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0]   ZERO_W  = '0;
   localparam logic [2*WIDTH-1:0] ZERO_2W = '0;
   localparam logic [WIDTH:0]     ZERO_W1 = '0;

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic             r_dz;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   // Working registers: r_acc_hi/r_acc_lo hold partial product or remainder/quotient.
   logic             r_is_div;
   logic             r_neg_q;     // product or quotient must be negated
   logic             r_neg_r;     // remainder must be negated (dividend sign)
   logic             r_div_zero;
   logic [WIDTH-1:0] r_b;         // multiplicand or divisor magnitude
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;
   logic [CW-1:0]    r_cnt;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_rem_sub;
   logic             w_rem_ge;
   logic [WIDTH-1:0] w_step_hi;
   logic [WIDTH-1:0] w_step_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_fin_hi;
   logic [WIDTH-1:0] w_fin_lo;

   // Operand magnitudes at issue; op_i[0]=1 marks the unsigned variants.
   always_comb begin
      w_a_neg = ~op_i[0] & a_i[WIDTH-1];
      w_b_neg = ~op_i[0] & b_i[WIDTH-1];
      w_a_mag = w_a_neg ? (ZERO_W - a_i) : a_i;
      w_b_mag = w_b_neg ? (ZERO_W - b_i) : b_i;
   end

   // One radix-2 iteration: shift-add multiply, or restoring subtract divide.
   always_comb begin
      w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : ZERO_W1);
      w_rem_sh  = {r_acc_hi, r_acc_lo[WIDTH-1]};
      w_rem_ge  = (w_rem_sh >= {1'b0, r_b});
      w_rem_sub = w_rem_sh - {1'b0, r_b};
      if (r_is_div) begin
         w_step_hi = w_rem_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
         w_step_lo = {r_acc_lo[WIDTH-2:0], w_rem_ge};
      end else begin
         w_step_hi = w_mul_sum[WIDTH:1];
         w_step_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
      end
   end

   // Sign correction of the finished magnitude result; divide-by-zero forces LO to all ones.
   always_comb begin
      w_prod = {r_acc_hi, r_acc_lo};
      if (r_is_div) begin
         w_fin_hi = r_neg_r ? (ZERO_W - r_acc_hi) : r_acc_hi;
         if (r_div_zero) begin
            w_fin_lo = ~ZERO_W;
         end else begin
            w_fin_lo = r_neg_q ? (ZERO_W - r_acc_lo) : r_acc_lo;
         end
      end else begin
         if (r_neg_q) begin
            w_prod = ZERO_2W - {r_acc_hi, r_acc_lo};
         end
         w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
         w_fin_lo = w_prod[WIDTH-1:0];
      end
   end

   // Control FSM with datapath and architectural HI/LO updates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_dz       <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
         r_b        <= '0;
         r_acc_hi   <= '0;
         r_acc_lo   <= '0;
         r_cnt      <= '0;
      end else begin
         r_done <= 1'b0;
         r_dz   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start_i && !flush_i) begin
                  r_state    <= CALC;
                  r_busy     <= 1'b1;
                  r_is_div   <= op_i[1];
                  r_neg_q    <= w_a_neg ^ w_b_neg;
                  r_neg_r    <= w_a_neg;
                  r_div_zero <= op_i[1] & (b_i == ZERO_W);
                  r_cnt      <= '0;
                  r_acc_hi   <= '0;
                  if (op_i[1]) begin
                     r_b      <= w_b_mag;
                     r_acc_lo <= w_a_mag;
                  end else begin
                     r_b      <= w_a_mag;
                     r_acc_lo <= w_b_mag;
                  end
               end else if (!start_i) begin
                  // start_i wins over a same-cycle MTHI/MTLO.
                  if (mthi_i) r_hi <= wdata_i;
                  if (mtlo_i) r_lo <= wdata_i;
               end
            end
            CALC: begin
               if (flush_i) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_acc_hi <= w_step_hi;
                  r_acc_lo <= w_step_lo;
                  r_cnt    <= r_cnt + CW'(1);
                  if (r_cnt == CW'(WIDTH - 1)) begin
                     r_state <= FINISH;
                  end
               end
            end
            FINISH: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               if (!flush_i) begin
                  r_hi   <= w_fin_hi;
                  r_lo   <= w_fin_lo;
                  r_done <= 1'b1;
                  r_dz   <= r_div_zero;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign div_zero_o = r_dz;
   assign hi_o       = r_hi;
   assign lo_o       = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Purpose : randomized + directed scoreboard bench for hilo_muldiv_unit (WIDTH=32).
// Latency : every accepted start expects done_o exactly WIDTH+2 cycles later.
// Backpres: driver only issues while busy_o=0; illegal starts while busy are injected and must be ignored.
`timescale 1ns/1ps
module tb_hilo_muldiv_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start_i = 1'b0;
   logic [1:0]    op_i = 2'd0;
   logic [W-1:0]  a_i = '0;
   logic [W-1:0]  b_i = '0;
   logic          flush_i = 1'b0;
   logic          mthi_i = 1'b0;
   logic          mtlo_i = 1'b0;
   logic [W-1:0]  wdata_i = '0;
   logic          busy_o, done_o, div_zero_o;
   logic [W-1:0]  hi_o, lo_o;

   hilo_muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
      .flush_i(flush_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i), .wdata_i(wdata_i),
      .busy_o(busy_o), .done_o(done_o), .div_zero_o(div_zero_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           cyc;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] mdl_hi = '0;
   logic [W-1:0] mdl_lo = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: plain 64-bit arithmetic on the architectural rules.
   function automatic void ref_model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
      logic signed [63:0] sa, sb_, sp, sq, sr;
      logic [63:0]        ua, ub, up;
      sa = $signed(a);
      sb_ = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      dz = 1'b0;
      case (op)
         0: begin sp = sa * sb_; hi = sp[63:32]; lo = sp[31:0]; end
         1: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
         default: begin
            if (b == '0) begin
               hi = a; lo = '1; dz = 1'b1;
            end else if (op == 2) begin
               sq = sa / sb_; sr = sa % sb_;
               hi = sr[31:0]; lo = sq[31:0];
            end else begin
               hi = a % b; lo = a / b;
            end
         end
      endcase
   endfunction

   // Monitor: pops the scoreboard on every done_o and flags missing or extra pulses.
   always @(negedge clk) begin
      if (!rst) begin
         if (sb.size() > 0 && !done_o && cyc > sb[0].cyc) begin
            n_vec++; n_err++;
            $display("FAIL done_missing: no done_o by cycle %0d expected at %0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (done_o) begin
            if (sb.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL done_unexpected: done_o at cycle %0d with nothing outstanding", cyc);
            end else begin
               mon_e = sb.pop_front();
               check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
               check("hi", {32'd0, hi_o}, {32'd0, mon_e.hi});
               check("lo", {32'd0, lo_o}, {32'd0, mon_e.lo});
               check("div_zero", {63'd0, div_zero_o}, {63'd0, mon_e.dz});
            end
         end
      end
   end

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Issue one op at an idle negedge; optionally poke an illegal start while busy or
   // collide an MTLO with the start. Returns at the done_o negedge.
   task automatic do_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, input bit mt_conflict);
      logic [W-1:0] h, l;
      logic         d;
      logic [W-1:0] lo_before;
      ref_model(op, a, b, h, l, d);
      lo_before = lo_o;
      start_i = 1'b1; op_i = 2'(op); a_i = a; b_i = b;
      if (mt_conflict) begin mtlo_i = 1'b1; wdata_i = 32'h0BAD_0BAD; end
      sb.push_back('{hi: h, lo: l, dz: d, cyc: cyc + W + 2});
      @(negedge clk);
      start_i = 1'b0; mtlo_i = 1'b0;
      if (mt_conflict) check("start_beats_mtlo", {32'd0, lo_o}, {32'd0, lo_before});
      if (poke) begin
         start_i = 1'b1; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
         @(negedge clk);
         start_i = 1'b0;
      end
      for (int i = 0; i < W + 10 && busy_o; i++) @(negedge clk);
      if (busy_o) begin
         n_vec++; n_err++;
         $display("FAIL busy_timeout: busy_o still %b after op %0d", busy_o, op);
      end
      mdl_hi = h; mdl_lo = l;
   endtask

   task automatic mt(input bit whi, input bit wlo, input logic [W-1:0] data);
      mthi_i = whi; mtlo_i = wlo; wdata_i = data;
      @(negedge clk);
      mthi_i = 1'b0; mtlo_i = 1'b0;
      if (whi) mdl_hi = data;
      if (wlo) mdl_lo = data;
      check("mt_hi", {32'd0, hi_o}, {32'd0, mdl_hi});
      check("mt_lo", {32'd0, lo_o}, {32'd0, mdl_lo});
   endtask

   task automatic check_state(input string name);
      check({name, "_busy"}, {63'd0, busy_o}, 64'd0);
      check({name, "_done"}, {63'd0, done_o}, 64'd0);
      check({name, "_hi"}, {32'd0, hi_o}, {32'd0, mdl_hi});
      check({name, "_lo"}, {32'd0, lo_o}, {32'd0, mdl_lo});
   endtask

   initial begin
      #1 rst = 1'b1;
      #2;
      check("rst_busy", {63'd0, busy_o}, 64'd0);
      check("rst_done", {63'd0, done_o}, 64'd0);
      check("rst_dz", {63'd0, div_zero_o}, 64'd0);
      check("rst_hi", {32'd0, hi_o}, 64'd0);
      check("rst_lo", {32'd0, lo_o}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed corner vectors, issued back-to-back in each done cycle.
      do_op(0, 32'hFFFF_FFFD, 32'd5, 0, 0);
      check("mult_neg3x5_hi", {32'd0, hi_o}, 64'h0000_0000_FFFF_FFFF);
      check("mult_neg3x5_lo", {32'd0, lo_o}, 64'h0000_0000_FFFF_FFF1);
      do_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      check("multu_max_hi", {32'd0, hi_o}, 64'h0000_0000_FFFF_FFFE);
      do_op(2, 32'hFFFF_FFF9, 32'd2, 0, 0);
      check("div_neg7_lo", {32'd0, lo_o}, 64'h0000_0000_FFFF_FFFD);
      do_op(2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      check("div_min_m1_lo", {32'd0, lo_o}, 64'h0000_0000_8000_0000);
      check("div_min_m1_hi", {32'd0, hi_o}, 64'd0);
      do_op(3, 32'd7, 32'd0, 0, 0);
      check("divu_zero_hi", {32'd0, hi_o}, 64'd7);
      do_op(2, 32'hFFFF_FFF0, 32'd0, 0, 0);
      do_op(0, 32'h8000_0000, 32'h8000_0000, 1, 0);
      do_op(3, 32'd100, 32'd7, 0, 1);

      // MTHI/MTLO, separately and together.
      mt(1, 0, 32'hA5A5_5A5A);
      mt(0, 1, 32'h1357_9BDF);
      mt(1, 1, 32'hCAFE_F00D);
      mt(0, 1, 32'h0000_1234);

      // Flush mid-CALC at cycle 10; MTHI during busy must be ignored.
      start_i = 1'b1; op_i = 2'd1; a_i = 32'd3; b_i = 32'd4;
      @(negedge clk);
      start_i = 1'b0;
      repeat (2) @(negedge clk);
      mthi_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
      @(negedge clk);
      mthi_i = 1'b0;
      check("mthi_busy_ignored", {32'd0, hi_o}, {32'd0, mdl_hi});
      repeat (6) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check_state("flush_calc");
      repeat (W + 6) @(negedge clk);

      // Flush in FINISH: the pending done_o must be suppressed.
      start_i = 1'b1; op_i = 2'd0; a_i = 32'd9; b_i = 32'd9;
      @(negedge clk);
      start_i = 1'b0;
      repeat (W) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check_state("flush_finish");
      repeat (4) @(negedge clk);

      // Asynchronous reset mid-CALC.
      start_i = 1'b1; op_i = 2'd2; a_i = 32'd1000; b_i = 32'd3;
      @(negedge clk);
      start_i = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      sb.delete();
      mdl_hi = '0; mdl_lo = '0;
      check_state("async_rst");
      check("async_rst_dz", {63'd0, div_zero_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (W + 6) @(negedge clk);
      check_state("post_rst");

      // Randomized ops with idle gaps, MT writes, illegal starts and MT/start collisions.
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if ($urandom_range(0, 4) == 0)
            mt(1'($urandom), 1'($urandom), $urandom);
         do_op(int'($urandom_range(0, 3)), rand_operand(), rand_operand(),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      end
      repeat (4) @(negedge clk);
      if (sb.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL scoreboard_leftover: %0d entries still pending, 0 required", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
